// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and helpers for the 1-to-N stream demultiplexer.
//   DROP_CNT_W : width of the saturating dropped-beat counter
//   sel_width  : select width for n channels, never less than 1 bit
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int DROP_CNT_W = 8;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// -----------------------------------------------------------------------------
// demux_out_slot
// One-entry output slot for a single demux channel.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : write i_data into the slot this cycle
//   i_data       : beat payload
//   i_ready      : downstream ready for this channel
//   o_valid      : slot holds a beat
//   o_data       : slot payload, zero while empty
//   o_can_load   : slot is empty or draining this cycle
// -----------------------------------------------------------------------------
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_can_load
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_drain;

    assign w_drain    = r_valid & i_ready;
    assign o_can_load = ~r_valid | i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

    // Load wins over drain so a simultaneous drain+load keeps the slot full
    // with the new beat; a plain drain clears the payload back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_drain) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
    end

endmodule

// File: rtl/demux_1xn_stream.sv
// -----------------------------------------------------------------------------
// demux_1xn_stream
// Routes a valid/ready input stream to one of N_CH output channels, each with
// its own one-entry slot. Out-of-range destinations are dropped and counted.
// Optional feature macro: DEMUX_TDM_EN -- when defined, tdm_mode=1 replaces
// s_sel with an internal round-robin pointer.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : input handshake; s_data payload, s_sel destination
//   tdm_mode          : round-robin destination request
//   m_valid/m_ready   : per-channel output handshake
//   m_data            : channel k at [k*DATA_W +: DATA_W]
//   err_drop          : one-cycle pulse after a dropped beat
//   drop_cnt          : saturating dropped-beat count
// -----------------------------------------------------------------------------
module demux_1xn_stream
    import demux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_CH   = 16,
    localparam int SEL_W  = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    input  logic [SEL_W-1:0]       s_sel,
    input  logic                   tdm_mode,
    output logic [N_CH-1:0]        m_valid,
    input  logic [N_CH-1:0]        m_ready,
    output logic [N_CH*DATA_W-1:0] m_data,
    output logic                   err_drop,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    logic [SEL_W-1:0]      w_dst;
    logic                  w_in_range;
    logic                  w_dst_rdy;
    logic                  w_accept;
    logic                  w_drop;
    logic [N_CH-1:0]       w_load;
    logic [N_CH-1:0]       w_can_load;
    logic                  r_err_drop;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

`ifdef DEMUX_TDM_EN
    logic [SEL_W-1:0] r_tdm_ptr;

    // Pointer only moves on accepted beats in TDM mode, so it holds its
    // position across tdm_mode low periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdm_ptr <= '0;
        end else if (tdm_mode && w_accept) begin
            r_tdm_ptr <= (r_tdm_ptr == SEL_W'(N_CH - 1)) ? '0 : r_tdm_ptr + 1'b1;
        end
    end

    assign w_dst = tdm_mode ? r_tdm_ptr : s_sel;
`else
    logic w_unused_tdm;

    assign w_unused_tdm = tdm_mode;
    assign w_dst        = s_sel;
`endif

    assign w_in_range = (32'(w_dst) < N_CH);

    // Out-of-range beats are always accepted so they can be dropped.
    always_comb begin
        w_dst_rdy = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (w_in_range && (w_dst == SEL_W'(k))) w_dst_rdy = w_can_load[k];
        end
    end

    assign s_ready  = w_dst_rdy;
    assign w_accept = s_valid & w_dst_rdy;
    assign w_drop   = w_accept & ~w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_drop <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_err_drop <= w_drop;
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign err_drop = r_err_drop;
    assign drop_cnt = r_drop_cnt;

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        assign w_load[k] = w_accept & w_in_range & (w_dst == SEL_W'(k));

        demux_out_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_load[k]),
            .i_data     (s_data),
            .i_ready    (m_ready[k]),
            .o_valid    (m_valid[k]),
            .o_data     (m_data[k*DATA_W +: DATA_W]),
            .o_can_load (w_can_load[k])
        );
    end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_1xn_stream
// Scoreboarded bench: a 16-channel instance carries the routing, stall,
// drain+load and reset cases; a 10-channel instance carries the drop cases;
// a 4-channel instance carries round-robin mode when DEMUX_TDM_EN is defined.
// -----------------------------------------------------------------------------
module tb_demux_1xn_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 16-channel instance
    logic         s_valid, s_ready, tdm_mode;
    logic [3:0]   s_sel;
    logic [7:0]   s_data;
    logic [15:0]  m_valid, m_ready;
    logic [127:0] m_data;
    logic         err_drop;
    logic [7:0]   drop_cnt;

    demux_1xn_stream #(.DATA_W(8), .N_CH(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sel(s_sel), .tdm_mode(tdm_mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_drop(err_drop), .drop_cnt(drop_cnt)
    );

    // 10-channel instance
    logic        t_valid, t_ready;
    logic [3:0]  t_sel;
    logic [7:0]  t_data;
    logic [9:0]  t_m_valid, t_m_ready;
    logic [79:0] t_m_data;
    logic        t_err_drop;
    logic [7:0]  t_drop_cnt;

    demux_1xn_stream #(.DATA_W(8), .N_CH(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .s_valid(t_valid), .s_ready(t_ready),
        .s_data(t_data), .s_sel(t_sel), .tdm_mode(1'b0),
        .m_valid(t_m_valid), .m_ready(t_m_ready), .m_data(t_m_data),
        .err_drop(t_err_drop), .drop_cnt(t_drop_cnt)
    );

`ifdef DEMUX_TDM_EN
    logic        p_valid, p_ready, p_tdm;
    logic [1:0]  p_sel;
    logic [7:0]  p_data;
    logic [3:0]  p_m_valid, p_m_ready;
    logic [31:0] p_m_data;
    logic        p_err_drop;
    logic [7:0]  p_drop_cnt;

    demux_1xn_stream #(.DATA_W(8), .N_CH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(p_valid), .s_ready(p_ready),
        .s_data(p_data), .s_sel(p_sel), .tdm_mode(p_tdm),
        .m_valid(p_m_valid), .m_ready(p_m_ready), .m_data(p_m_data),
        .err_drop(p_err_drop), .drop_cnt(p_drop_cnt)
    );
`endif

    // Expected beats per channel of the 16-channel instance
    logic [7:0] exp_q[16][$];
    logic [7:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer must match the head of that channel's queue,
    // and an empty slot must present zero data.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 16; k++) begin
                if (m_valid[k] && m_ready[k]) begin
                    n_tests++;
                    if (exp_q[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_unexpected ch%0d: got 0x%0h, expected no beat", k, m_data[k*8 +: 8]);
                    end else begin
                        mon_e = exp_q[k].pop_front();
                        if (m_data[k*8 +: 8] !== mon_e) begin
                            n_fail++;
                            $display("FAIL mon_data ch%0d: got 0x%0h, expected 0x%0h", k, m_data[k*8 +: 8], mon_e);
                        end
                    end
                end
                if (!m_valid[k]) begin
                    n_tests++;
                    if (m_data[k*8 +: 8] !== 8'h00) begin
                        n_fail++;
                        $display("FAIL mon_zero ch%0d: got 0x%0h, expected 0x0", k, m_data[k*8 +: 8]);
                    end
                end
            end
        end
    end

    task automatic present(input logic [3:0] sel, input logic [7:0] d);
        @(posedge clk); #1;
        s_valid = 1'b1; s_sel = sel; s_data = d;
    endtask

    task automatic accept(input logic exp_rdy);
        @(negedge clk);
        check("s_ready", {31'd0, s_ready}, {31'd0, exp_rdy});
        if (s_ready) exp_q[s_sel].push_back(s_data);
    endtask

    task automatic beat(input logic [3:0] sel, input logic [7:0] d, input logic exp_rdy);
        present(sel, d);
        accept(exp_rdy);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    initial begin
        s_valid = 0; s_sel = 0; s_data = 0; tdm_mode = 0; m_ready = '1;
        t_valid = 0; t_sel = 0; t_data = 0; t_m_ready = '1;
`ifdef DEMUX_TDM_EN
        p_valid = 0; p_sel = 0; p_data = 0; p_tdm = 0; p_m_ready = '1;
`endif
        #12;
        check("rst_mvalid", {16'd0, m_valid}, 32'd0);
        check("rst_mdata", {31'd0, |m_data}, 32'd0);
        check("rst_err", {31'd0, err_drop}, 32'd0);
        check("rst_cnt", {24'd0, drop_cnt}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Routing: each channel in turn, one-cycle latency
        for (int k = 0; k < 16; k++) begin
            beat(4'(k), 8'hA0 + 8'(k), 1'b1);
            if (k > 0) begin
                check("route_onehot", {16'd0, m_valid}, 32'(16'(1 << (k - 1))));
                check("route_data", {24'd0, m_data[(k-1)*8 +: 8]}, {24'd0, 8'hA0 + 8'(k - 1)});
            end
        end
        idle();
        @(negedge clk);
        check("route_last", {16'd0, m_valid}, 32'h8000);
        check("route_last_data", {24'd0, m_data[120 +: 8]}, 32'hAF);

        // Stall on channel 3, channel 5 unaffected
        present(4'd3, 8'h33); m_ready = 16'hFFF7; accept(1'b1);
        beat(4'd3, 8'h34, 1'b0);
        check("stall_v3", {31'd0, m_valid[3]}, 32'd1);
        beat(4'd5, 8'h55, 1'b1);
        check("stall_hold3", {24'd0, m_data[24 +: 8]}, 32'h33);
        present(4'd3, 8'h34); m_ready[3] = 1'b1; accept(1'b1);
        check("stall_v5", {31'd0, m_valid[5]}, 32'd1);
        check("release_first", {24'd0, m_data[24 +: 8]}, 32'h33);
        idle();
        @(negedge clk);
        check("release_v3", {31'd0, m_valid[3]}, 32'd1);
        check("release_second", {24'd0, m_data[24 +: 8]}, 32'h34);
        @(negedge clk);
        check("release_empty", {31'd0, m_valid[3]}, 32'd0);

        // Drain and reload of channel 4 in the same cycle
        beat(4'd4, 8'h41, 1'b1);
        beat(4'd4, 8'h42, 1'b1);
        check("dl_v4_a", {31'd0, m_valid[4]}, 32'd1);
        check("dl_data_a", {24'd0, m_data[32 +: 8]}, 32'h41);
        idle();
        @(negedge clk);
        check("dl_v4_b", {31'd0, m_valid[4]}, 32'd1);
        check("dl_data_b", {24'd0, m_data[32 +: 8]}, 32'h42);

        // Reset with slots 2 and 7 full
        m_ready = 16'hFF7B;
        beat(4'd2, 8'h22, 1'b1);
        beat(4'd7, 8'h77, 1'b1);
        idle();
        @(negedge clk);
        check("pre_rst_full", {16'd0, m_valid}, 32'h0084);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mvalid", {16'd0, m_valid}, 32'd0);
        check("mid_rst_mdata", {31'd0, |m_data}, 32'd0);
        check("mid_rst_cnt", {24'd0, drop_cnt}, 32'd0);
        exp_q[2].delete();
        exp_q[7].delete();
        @(posedge clk); #1 rst_n = 1'b1; m_ready = '1;
        beat(4'd2, 8'h5A, 1'b1);
        idle();
        @(negedge clk);
        check("post_rst_v", {16'd0, m_valid}, 32'h0004);
        check("post_rst_data", {24'd0, m_data[16 +: 8]}, 32'h5A);

        // Drops on the 10-channel instance
        @(posedge clk); #1 t_valid = 1'b1; t_sel = 4'd12; t_data = 8'hEE;
        @(negedge clk);
        check("drop_rdy", {31'd0, t_ready}, 32'd1);
        @(posedge clk); #1 t_valid = 1'b0;
        @(negedge clk);
        check("drop_pulse", {31'd0, t_err_drop}, 32'd1);
        check("drop_cnt1", {24'd0, t_drop_cnt}, 32'd1);
        check("drop_no_mvalid", {22'd0, t_m_valid}, 32'd0);
        @(negedge clk);
        check("drop_pulse_end", {31'd0, t_err_drop}, 32'd0);
        @(posedge clk); #1 t_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1 t_valid = 1'b0;
        @(negedge clk);
        check("drop_sat", {24'd0, t_drop_cnt}, 32'd255);
        check("drop_sat_mvalid", {22'd0, t_m_valid}, 32'd0);
        @(posedge clk); #1 t_valid = 1'b1; t_sel = 4'd9; t_data = 8'h99;
        @(posedge clk); #1 t_valid = 1'b0;
        @(negedge clk);
        check("dut10_ch9", {22'd0, t_m_valid}, 32'h200);
        check("dut10_ch9_data", {24'd0, t_m_data[72 +: 8]}, 32'h99);
        check("dut10_cnt_held", {24'd0, t_drop_cnt}, 32'd255);

`ifdef DEMUX_TDM_EN
        // Round-robin: destinations 0,1,2,3,0,1 regardless of p_sel
        p_tdm = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 p_valid = 1'b1; p_sel = 2'd3; p_data = 8'h60 + 8'(i);
            @(negedge clk);
            if (i > 0) check("tdm_dst", {28'd0, p_m_valid}, 32'(4'(1 << ((i - 1) % 4))));
        end
        @(posedge clk); #1 p_valid = 1'b0;
        @(negedge clk);
        check("tdm_dst_last", {28'd0, p_m_valid}, 32'h2);
        // Pointer holds while tdm_mode is low
        @(posedge clk); #1 p_tdm = 1'b0; p_valid = 1'b1; p_sel = 2'd3;
        @(posedge clk); #1 p_tdm = 1'b1;
        @(negedge clk);
        check("tdm_off_sel", {28'd0, p_m_valid}, 32'h8);
        @(posedge clk); #1 p_valid = 1'b0;
        @(negedge clk);
        check("tdm_resume", {28'd0, p_m_valid}, 32'h4);
`endif

        repeat (3) @(posedge clk);
        for (int k = 0; k < 16; k++) check("queue_empty", exp_q[k].size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
